// File: rtl/boruss_control_unit.sv
// Multi-cycle sequencer for boruss_alu: fetch/decode/exec/writeback over a 4-entry
// register file. States: IDLE wait run | FETCH read imem | DECODE load IR | EXEC drive ALU | WB commit | HALT sticky stop
module boruss_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [7:0]  imem_addr,
    output logic        imem_rd_en,
    input  logic [15:0] imem_data,
    output logic [7:0]  operand_a,
    output logic [7:0]  operand_b,
    output logic [7:0]  operation_code,
    input  logic [7:0]  result,
    input  logic        zero_flag,
    input  logic        carry_flag,
    input  logic        negative_flag,
    output logic [2:0]  flags,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        instr_retired,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    logic [7:0]  pc_q;
    logic [15:0] ir;
    logic [7:0]  regs [4];
    logic [2:0]  flags_q;
    logic [7:0]  res_q;
    logic [2:0]  alu_flags_q;

    logic [3:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic [7:0]  pc_inc;

    assign op     = ir[15:12];
    assign rd     = ir[11:10];
    assign rs     = ir[9:8];
    assign imm    = ir[7:0];
    assign pc_inc = pc_q + 8'd1;

    // ALU port values are a Moore decode of state and IR; idle pattern is 0/0/FF.
    always_comb begin
        operand_a      = 8'h00;
        operand_b      = 8'h00;
        operation_code = 8'hFF;
        if (state == S_EXEC) begin
            if (!op[3] || op == 4'hF) begin
                operand_a      = regs[rd];
                operand_b      = regs[rs];
                operation_code = {4'h0, op};
            end else if (op == 4'h8) begin
                operand_a      = 8'h00;
                operand_b      = imm;
                operation_code = 8'h08;
            end
        end
    end

    assign imem_rd_en    = (state == S_FETCH);
    assign imem_addr     = (state == S_FETCH) ? pc_q : 8'h00;
    assign halted        = (state == S_HALT);
    assign instr_retired = (state == S_WB);
    assign flags         = flags_q;
    assign pc            = pc_q;
    assign dbg_data      = regs[dbg_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_q        <= 8'h00;
            ir          <= 16'h0000;
            flags_q     <= 3'b000;
            res_q       <= 8'h00;
            alu_flags_q <= 3'b000;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir    <= imem_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_q       <= result;
                    alu_flags_q <= {zero_flag, carry_flag, negative_flag};
                    state       <= S_WB;
                end
                S_WB: begin
                    case (op)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            regs[rd] <= res_q;
                            flags_q  <= alu_flags_q;
                            pc_q     <= pc_inc;
                        end
                        4'hF: begin
                            flags_q <= alu_flags_q;
                            pc_q    <= pc_inc;
                        end
                        4'h8: pc_q <= res_q;
                        4'h9: begin
                            regs[rd] <= imm;
                            pc_q     <= pc_inc;
                        end
                        // Branches see flags as they stood at EXEC; only WB writes flags.
                        4'hA: pc_q <= flags_q[2] ? imm : pc_inc;
                        4'hB: pc_q <= flags_q[1] ? imm : pc_inc;
                        4'hE: pc_q <= pc_q;
                        default: pc_q <= pc_inc;
                    endcase
                    if (op == 4'hE)
                        state <= S_HALT;
                    else if (run)
                        state <= S_FETCH;
                    else
                        state <= S_IDLE;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boruss_control_unit.sv
// Directed bench for boruss_control_unit with a behavioural ALU and synchronous program memory.
module tb_boruss_control_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_data;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [7:0]  operation_code;
    logic [7:0]  result;
    logic        zero_flag;
    logic        carry_flag;
    logic        negative_flag;
    logic [2:0]  flags;
    logic [7:0]  pc;
    logic        halted;
    logic        instr_retired;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    boruss_control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_data      (imem_data),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .operation_code (operation_code),
        .result         (result),
        .zero_flag      (zero_flag),
        .carry_flag     (carry_flag),
        .negative_flag  (negative_flag),
        .flags          (flags),
        .pc             (pc),
        .halted         (halted),
        .instr_retired  (instr_retired),
        .dbg_sel        (dbg_sel),
        .dbg_data       (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= mem[imem_addr];
    end

    // Reference ALU: carry is the borrow on subtract.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'h000;
        case (operation_code)
            8'h00, 8'h08: alu_wide = {1'b0, operand_a} + {1'b0, operand_b};
            8'h01, 8'h0F: alu_wide = {1'b0, operand_a} - {1'b0, operand_b};
            8'h02: alu_wide = {1'b0, operand_a & operand_b};
            8'h03: alu_wide = {1'b0, operand_a | operand_b};
            8'h04: alu_wide = {1'b0, operand_a ^ operand_b};
            8'h05: alu_wide = {1'b0, ~operand_a};
            8'h06: alu_wide = {operand_a, 1'b0};
            8'h07: alu_wide = {operand_a[0], 1'b0, operand_a[7:1]};
            default: alu_wide = 9'h000;
        endcase
        result        = alu_wide[7:0];
        carry_flag    = alu_wide[8];
        zero_flag     = (alu_wide[7:0] == 8'h00);
        negative_flag = alu_wide[7];
    end

    int n_checks;
    int n_fail;

    int         ret_cyc [8];
    logic [7:0] fetch_addr [8];
    logic [2:0] flags_after [8];
    logic [7:0] dbg_after [8];
    logic [7:0] exec_op [8];
    logic [7:0] exec_a [8];
    int         n_ret;
    int         n_fetch;
    int         first_fetch;
    int         last_fetch;
    int         halt_cyc;
    bit         timeout;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask

    // Raises run and records fetch/retire/exec activity until halted or the budget runs out.
    task automatic run_prog(input int budget, input bit expect_halt);
        bit ret_prev;
        n_ret = 0; n_fetch = 0; first_fetch = -1; last_fetch = -10; halt_cyc = -1;
        timeout = 1'b0; ret_prev = 1'b0;
        run = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (imem_rd_en) begin
                if (n_fetch < 8) fetch_addr[n_fetch] = imem_addr;
                if (first_fetch < 0) first_fetch = cyc;
                last_fetch = cyc;
                n_fetch++;
            end
            if (cyc == last_fetch + 2 && n_fetch >= 1 && n_fetch <= 8) begin
                exec_op[n_fetch-1] = operation_code;
                exec_a[n_fetch-1]  = operand_a;
            end
            if (ret_prev && n_ret >= 1 && n_ret <= 8) begin
                flags_after[n_ret-1] = flags;
                dbg_after[n_ret-1]   = dbg_data;
            end
            ret_prev = instr_retired;
            if (instr_retired) begin
                if (n_ret < 8) ret_cyc[n_ret] = cyc;
                n_ret++;
            end
            if (halted) begin
                halt_cyc = cyc;
                break;
            end
        end
        if (expect_halt && !halted) timeout = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, expected 0", imem_rd_en); end
        n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h, expected 00", imem_addr); end
        n_checks++; if ({operand_a, operand_b, operation_code} !== 24'h0000FF) begin n_fail++; $display("FAIL reset_alu_ports: got %h, expected 0000ff", {operand_a, operand_b, operation_code}); end
        n_checks++; if ({halted, instr_retired, flags, pc} !== 13'h0) begin n_fail++; $display("FAIL reset_status: got %h, expected 0", {halted, instr_retired, flags, pc}); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0];
            #1;
            n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h, expected 00", i, dbg_data); end
        end
    endtask

    task automatic test_add();
        fill_halt();
        mem[0] = 16'h900A;
        mem[1] = 16'h9405;
        mem[2] = 16'h0100;
        dbg_sel = 2'd0;
        do_reset();
        run_prog(60, 1'b1);
        run = 1'b0;
        n_checks++; if (timeout) begin n_fail++; $display("FAIL add_timeout: got no halt, expected halt within 60 cycles"); end
        n_checks++; if (first_fetch !== 1) begin n_fail++; $display("FAIL add_first_fetch: got cycle %0d, expected 1", first_fetch); end
        n_checks++; if ({ret_cyc[0], ret_cyc[1], ret_cyc[2], ret_cyc[3]} !== {32'd4, 32'd8, 32'd12, 32'd16}) begin n_fail++; $display("FAIL add_retire_cycles: got %0d %0d %0d %0d, expected 4 8 12 16", ret_cyc[0], ret_cyc[1], ret_cyc[2], ret_cyc[3]); end
        n_checks++; if (dbg_after[2] !== 8'd15) begin n_fail++; $display("FAIL add_r0: got %0d, expected 15", dbg_after[2]); end
        n_checks++; if (flags_after[2] !== 3'b000) begin n_fail++; $display("FAIL add_flags: got %b, expected 000", flags_after[2]); end
        n_checks++; if (pc !== 8'h03) begin n_fail++; $display("FAIL add_pc: got %h, expected 03", pc); end
        n_checks++; if (halt_cyc !== 17) begin n_fail++; $display("FAIL add_halt_cycle: got %0d, expected 17", halt_cyc); end
    endtask

    task automatic test_jz();
        fill_halt();
        mem[0] = 16'h98FF;
        mem[1] = 16'h9C01;
        mem[2] = 16'h0B00;
        mem[3] = 16'hA020;
        mem[4] = 16'hC000;
        dbg_sel = 2'd2;
        do_reset();
        run_prog(60, 1'b1);
        run = 1'b0;
        n_checks++; if (timeout) begin n_fail++; $display("FAIL jz_timeout: got no halt, expected halt within 60 cycles"); end
        n_checks++; if (dbg_after[2] !== 8'h00) begin n_fail++; $display("FAIL jz_r2: got %h, expected 00", dbg_after[2]); end
        n_checks++; if (flags_after[2] !== 3'b110) begin n_fail++; $display("FAIL jz_flags: got %b, expected 110", flags_after[2]); end
        n_checks++; if (fetch_addr[4] !== 8'h20) begin n_fail++; $display("FAIL jz_target: got %h, expected 20", fetch_addr[4]); end
        n_checks++; if (pc !== 8'h20) begin n_fail++; $display("FAIL jz_pc: got %h, expected 20", pc); end
    endtask

    task automatic test_sub_cmp();
        fill_halt();
        mem[0] = 16'h9005;
        mem[1] = 16'h940A;
        mem[2] = 16'h1100;
        mem[3] = 16'hF500;
        dbg_sel = 2'd0;
        do_reset();
        run_prog(60, 1'b1);
        run = 1'b0;
        n_checks++; if (timeout) begin n_fail++; $display("FAIL sub_timeout: got no halt, expected halt within 60 cycles"); end
        n_checks++; if (dbg_after[2] !== 8'd251) begin n_fail++; $display("FAIL sub_r0: got %0d, expected 251", dbg_after[2]); end
        n_checks++; if (flags_after[2] !== 3'b011) begin n_fail++; $display("FAIL sub_flags: got %b, expected 011", flags_after[2]); end
        n_checks++; if (exec_op[2] !== 8'h01) begin n_fail++; $display("FAIL sub_opcode: got %h, expected 01", exec_op[2]); end
        n_checks++; if (flags_after[3] !== 3'b100) begin n_fail++; $display("FAIL cmp_flags: got %b, expected 100", flags_after[3]); end
        n_checks++; if (exec_op[3] !== 8'h0F) begin n_fail++; $display("FAIL cmp_opcode: got %h, expected 0f", exec_op[3]); end
        n_checks++; if (exec_a[3] !== 8'd10) begin n_fail++; $display("FAIL cmp_operand_a: got %0d, expected 10", exec_a[3]); end
        dbg_sel = 2'd1;
        #1;
        n_checks++; if (dbg_data !== 8'd10) begin n_fail++; $display("FAIL cmp_r1: got %0d, expected 10", dbg_data); end
    endtask

    task automatic test_jmp_wrap();
        fill_halt();
        mem[0]   = 16'h80FF;
        mem[255] = 16'hC000;
        do_reset();
        run_prog(14, 1'b0);
        run = 1'b0;
        n_checks++; if (n_fetch !== 4) begin n_fail++; $display("FAIL jmp_fetch_count: got %0d, expected 4", n_fetch); end
        n_checks++; if ({fetch_addr[0], fetch_addr[1], fetch_addr[2]} !== 24'h00FF00) begin n_fail++; $display("FAIL jmp_addr_seq: got %h %h %h, expected 00 ff 00", fetch_addr[0], fetch_addr[1], fetch_addr[2]); end
        n_checks++; if (exec_op[0] !== 8'h08) begin n_fail++; $display("FAIL jmp_opcode: got %h, expected 08", exec_op[0]); end
    endtask

    task automatic test_halt();
        int rd_seen;
        fill_halt();
        do_reset();
        run_prog(30, 1'b1);
        n_checks++; if (timeout) begin n_fail++; $display("FAIL halt_timeout: got no halt, expected halt within 30 cycles"); end
        n_checks++; if (halt_cyc !== 5 || ret_cyc[0] !== 4) begin n_fail++; $display("FAIL halt_timing: got halt %0d retire %0d, expected 5 and 4", halt_cyc, ret_cyc[0]); end
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_rd_en || !halted) rd_seen++;
        end
        n_checks++; if (rd_seen !== 0) begin n_fail++; $display("FAIL halt_sticky: got %0d active cycles, expected 0", rd_seen); end
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL halt_pc: got %h, expected 00", pc); end
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({halted, pc} !== 9'h000) begin n_fail++; $display("FAIL halt_reset: got halted %b pc %h, expected 0 00", halted, pc); end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_halt();
        mem[0] = 16'h900A;
        mem[1] = 16'h9405;
        mem[2] = 16'h0100;
        dbg_sel = 2'd0;
        do_reset();
        run = 1'b1;
        repeat (11) @(negedge clk);
        n_checks++; if (operation_code !== 8'h00 || operand_a !== 8'd10) begin n_fail++; $display("FAIL mid_exec: got op %h a %0d, expected 00 10", operation_code, operand_a); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        n_checks++; if ({dbg_data, flags} !== 11'h0) begin n_fail++; $display("FAIL mid_regs: got r0 %h flags %b, expected 00 000", dbg_data, flags); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (instr_retired || imem_rd_en || operation_code !== 8'hFF) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mid_idle: got %0d active cycles, expected 0", bad); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        run      = 1'b0;
        dbg_sel  = 2'd0;
        test_reset();
        test_add();
        test_jz();
        test_sub_cmp();
        test_jmp_wrap();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
